// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte per accepted load as
// start bit, 7/8 data bits LSB-first, optional parity, one stop bit.
// Optional busy-load overflow flag enabled by defining UART_TX_OVF_EN.
module uart_tx_engine #(
  parameter int unsigned BAUD_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_val,
`ifdef UART_TX_OVF_EN
  input  logic              clr_ovf,
  output logic              txovf,
`endif
  output logic              tx,
  output logic              txrdy,
  output logic              tx_done
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  localparam logic [BAUD_W-1:0] One = {{(BAUD_W-1){1'b0}}, 1'b1};

  state_e              r_state, w_state_d;
  logic [BAUD_W-1:0]   r_cnt, w_cnt_d;    // clocks left in current bit, minus one
  logic [BAUD_W-1:0]   r_bt, w_bt_d;      // bit time minus one, reload value
  logic [7:0]          r_data, w_data_d;
  logic                r_eight, w_eight_d;
  logic                r_pen, w_pen_d;
  logic                r_ohel, w_ohel_d;
  logic [2:0]          r_bit, w_bit_d;    // index of data bit being driven
  logic                r_tx, w_tx_d;

  logic [7:0] w_mask;
  logic       w_par;
  logic       w_last;
  logic [2:0] w_bit_inc;

  assign w_mask    = r_eight ? 8'hFF : 8'h7F;
  assign w_par     = (^(r_data & w_mask)) ^ r_ohel;
  assign w_last    = (r_bit == (r_eight ? 3'd7 : 3'd6));
  assign w_bit_inc = r_bit + 3'd1;

  // Next-state logic: load capture in idle, bit sequencing at each bit boundary.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_bt_d    = r_bt;
    w_data_d  = r_data;
    w_eight_d = r_eight;
    w_pen_d   = r_pen;
    w_ohel_d  = r_ohel;
    w_bit_d   = r_bit;
    w_tx_d    = r_tx;
    if (r_state == StIdle) begin
      w_tx_d = 1'b1;
      if (load) begin
        w_data_d  = out_port;
        w_eight_d = eight;
        w_pen_d   = pen;
        w_ohel_d  = ohel;
        // A zero bit time behaves as one clock per bit.
        w_bt_d    = (baud_val == '0) ? '0 : (baud_val - One);
        w_cnt_d   = (baud_val == '0) ? '0 : (baud_val - One);
        w_bit_d   = 3'd0;
        w_state_d = StStart;
        w_tx_d    = 1'b0;
      end
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - One;
    end else begin
      w_cnt_d = r_bt;
      unique case (r_state)
        StStart: begin
          w_state_d = StData;
          w_bit_d   = 3'd0;
          w_tx_d    = r_data[0];
        end
        StData: begin
          if (!w_last) begin
            w_bit_d = w_bit_inc;
            w_tx_d  = r_data[w_bit_inc];
          end else if (r_pen) begin
            w_state_d = StParity;
            w_tx_d    = w_par;
          end else begin
            w_state_d = StStop;
            w_tx_d    = 1'b1;
          end
        end
        StParity: begin
          w_state_d = StStop;
          w_tx_d    = 1'b1;
        end
        StStop: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
          w_tx_d    = 1'b1;
        end
        default: begin
          w_state_d = StIdle;
          w_tx_d    = 1'b1;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset; abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bt    <= '0;
      r_data  <= 8'h00;
      r_eight <= 1'b0;
      r_pen   <= 1'b0;
      r_ohel  <= 1'b0;
      r_bit   <= 3'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_bt    <= w_bt_d;
      r_data  <= w_data_d;
      r_eight <= w_eight_d;
      r_pen   <= w_pen_d;
      r_ohel  <= w_ohel_d;
      r_bit   <= w_bit_d;
      r_tx    <= w_tx_d;
    end
  end

  assign tx      = r_tx;
  assign txrdy   = (r_state == StIdle);
  assign tx_done = (r_state == StStop) && (r_cnt == '0);

`ifdef UART_TX_OVF_EN
  logic r_txovf;

  // Sticky overflow flag: a busy-time load sets it, set beats clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_txovf <= 1'b0;
    end else if (load && (r_state != StIdle)) begin
      r_txovf <= 1'b1;
    end else if (clr_ovf) begin
      r_txovf <= 1'b0;
    end
  end

  assign txovf = r_txovf;
`endif

endmodule
